dac_scheduler: RTL
==================

DAC_SCHEDULER -- requirements
Module: dac_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 4, giving the minimum idle cycles between the end of one DAC frame and the next grant (range 0..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for transmit_complete (range 1..255; must exceed one SPI frame).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, the only clock.
REQ-004 The block SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 2 bits: per-channel sample-valid flags (bit i = channel i).
REQ-006 The block SHALL have port req0_data, input, 10 bits: channel 0 sample.
REQ-007 The block SHALL have port req1_data, input, 10 bits: channel 1 sample.
REQ-008 The block SHALL have port req_ready, output, 2 bits: per-channel accept strobe.
REQ-009 The block SHALL have port dac_data, output, 10 bits: sample driven to the DAC driver.
REQ-010 The block SHALL have port start_transmit, output, 1 bit: one-cycle frame-start pulse to the DAC driver.
REQ-011 The block SHALL have port transmit_complete, input, 1 bit: frame-done pulse from the SPI engine.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The block SHALL have port active_ch, output, 1 bit: channel of the most recently granted sample.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: sticky frame-timeout flag.
REQ-015 The block SHALL have port clear_err, input, 1 bit: synchronous clear for timeout_err.

Function
REQ-016 The FSM SHALL have states IDLE, START, BUSY and GAP, all clocked on the rising edge of clk.
REQ-017 req_ready SHALL be asserted only in IDLE, and combinationally on exactly one bit: the granted channel, or 2'b00 when req_valid==0.
REQ-018 A transfer SHALL occur when req_valid[i] && req_ready[i].
- In that cycle the block SHALL latch the channel data into dac_data, set active_ch=i and go to START.
REQ-019 Arbitration SHALL be round-robin.
- If only one channel is valid, that channel is granted.
- If both are valid, the channel other than the last granted one is granted.
- After reset, channel 0 has priority.
REQ-020 In START, start_transmit SHALL be 1 for exactly one cycle, then the FSM SHALL go to BUSY.
- Frame latency: transfer at cycle T gives start_transmit=1 at T+1 and BUSY from T+2.
REQ-021 dac_data SHALL stay stable from the cycle after transfer until the next transfer, and SHALL otherwise hold its last value.
REQ-022 In BUSY, an 8-bit counter SHALL start at 0 on entry and increment each cycle.
- transmit_complete=1 → GAP next cycle.
- Otherwise, counter==TIMEOUT_CYCLES-1 → GAP next cycle with timeout_err set.
REQ-023 If transmit_complete and the timeout condition occur in the same cycle, completion SHALL win and timeout_err SHALL be left unchanged.
REQ-024 transmit_complete SHALL be ignored in IDLE, START and GAP.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles before IDLE; with GAP_CYCLES=0 the FSM SHALL go from BUSY directly to IDLE.
REQ-026 timeout_err SHALL be cleared by clear_err=1; if set and clear occur in the same cycle, set SHALL win.
REQ-027 req_valid changes outside IDLE SHALL have no effect; requesters hold valid until they see ready.

Reset
REQ-028 While nrst=0, regardless of state:
- state=IDLE
- dac_data=0
- start_transmit=0
- req_ready=0
- busy=0
- active_ch=0
- timeout_err=0
- round-robin pointer favours channel 0
- counters=0
REQ-029 Reset mid-frame SHALL abort with no further start_transmit pulse; operation SHALL resume from IDLE on the first clk edge after nrst rises.

Verification
REQ-030 Single request: req_valid=01, req0_data=10'h2A5, complete 20 cycles after start.
- req_ready=01 for 1 cycle.
- start_transmit pulse next cycle with dac_data=10'h2A5.
- busy drops exactly GAP_CYCLES+1 cycles after complete.
REQ-031 Contention: req_valid=11 held, data ch0=10'h001 and ch1=10'h3FF, complete every frame.
- Grants alternate ch0, ch1, ch0, ch1.
- dac_data alternates 001/3FF; active_ch tracks the grant.
REQ-032 Timeout: one grant, transmit_complete never asserted.
- FSM leaves BUSY after 255 cycles.
- timeout_err=1 and stays 1 until clear_err pulses.
- A next request is still served.
REQ-033 Same-cycle complete and timeout: complete pulsed at counter==254 → timeout_err remains 0.
REQ-034 Reset in BUSY: nrst low for 3 cycles → all outputs zero immediately (asynchronous), no stray start_transmit; the next req1 request is granted normally.
REQ-035 GAP_CYCLES=0 build: back-to-back req0 requests → next req_ready the cycle after transmit_complete.

Source files
------------

// File: rtl/dac_scheduler.sv
// Two-channel round-robin sample scheduler feeding a DAC driver: grants one
// sample, pulses start_transmit, waits for completion (or times out), then idles.
module dac_scheduler #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req_valid,
    input  logic [9:0] req0_data,
    input  logic [9:0] req1_data,
    output logic [1:0] req_ready,
    output logic [9:0] dac_data,
    output logic       start_transmit,
    input  logic       transmit_complete,
    output logic       busy,
    output logic       active_ch,
    output logic       timeout_err,
    input  logic       clear_err
);

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic       prio;
    logic       grant_ch;
    logic [1:0] grant;
    logic       frame_done;
    logic       timed_out;

    // prio is the channel that wins when both request; it flips to the loser on each grant
    always_comb begin
        grant_ch = 1'b0;
        case (req_valid)
            2'b01:   grant_ch = 1'b0;
            2'b10:   grant_ch = 1'b1;
            2'b11:   grant_ch = prio;
            default: grant_ch = 1'b0;
        endcase
        grant = '0;
        if (state == IDLE && nrst && (|req_valid))
            grant = grant_ch ? 2'b10 : 2'b01;
    end

    assign frame_done = (state == BUSY) && (transmit_complete || cnt == TO_LAST);
    assign timed_out  = (state == BUSY) && !transmit_complete && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (|grant) state_next = START;
            START: state_next = BUSY;
            BUSY:  if (frame_done) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = grant;
        start_transmit = (state == START);
        busy           = (state != IDLE);
    end

    // cnt restarts on every state change, so it serves both the BUSY timeout and the GAP length
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dac_data    <= '0;
            active_ch   <= 1'b0;
            prio        <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (|grant) begin
                dac_data  <= grant_ch ? req1_data : req0_data;
                active_ch <= grant_ch;
                prio      <= ~grant_ch;
            end
            if (state_next != state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;
            if (timed_out)
                timeout_err <= 1'b1;
            else if (clear_err)
                timeout_err <= 1'b0;
        end
    end

endmodule
